hazard_ctrl: RTL

Pipeline control unit for the 5-stage RV32I core. It consumes branch/jump resolution (`branch_taken`, `branch_target`, `ex_valid`) from `ex_stage`, plus load-use operand information and the data-memory busy flag. It drives PC redirect, stage write-enables and bubble (flush) controls so that EX-resolved control flow, load-use hazards and memory back-pressure are sequenced correctly. It also keeps saturating stall/flush counters and a sticky misaligned-target flag.

---
 rtl/ctrl_pkg.sv | 13 +
 rtl/load_use_detect.sv | 24 ++
 rtl/hazard_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the pipeline control slice.
// Holds the hazard FSM state encoding, the x0 index and the default counter width.
package ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    REDIRECT = 1'b1
  } state_t;

  localparam logic [4:0] X0        = 5'd0;
  localparam int         CNT_W_DEF = 16;

endpackage

// File: rtl/load_use_detect.sv
// Load-use comparator: flags an ID source that needs the result of a load still in EX.
// Purely combinational, zero latency; no flow control of its own.
module load_use_detect
  import ctrl_pkg::*;
(
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  output logic       lu
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);

  // x0 is never really written, so a load targeting it cannot create a hazard
  assign lu = ex_mem_read && (ex_rd != X0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline control: sequences EX redirects, load-use stalls and data-memory freezes.
// Controls are combinational from state/inputs; mem_busy freezes everything and holds state.
module hazard_ctrl
  import ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             pc_sel,
  output logic [31:0]      redirect_pc,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             misalign_err,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t state;
  logic   lu;
  logic   take;

  load_use_detect u_lu (
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .lu          (lu)
  );

  // In REDIRECT, EX holds the bubble inserted last cycle, so its branch is ignored
  assign take = (state == RUN) && ex_valid && branch_taken;

  always_comb begin
    pc_write     = 1'b1;
    pc_sel       = 1'b0;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    ex_mem_write = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    if (reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
    end else if (mem_busy) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
    end else if (state == REDIRECT) begin
      pc_sel      = 1'b1;
      if_id_flush = 1'b1;
    end else if (take) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (lu) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      redirect_pc  <= 32'd0;
      flush_count  <= '0;
      stall_count  <= '0;
      misalign_err <= 1'b0;
    end else if (mem_busy) begin
      if (stall_count != CNT_MAX) stall_count <= stall_count + CNT_ONE;
    end else if (state == REDIRECT) begin
      state <= RUN;
    end else if (take) begin
      state       <= REDIRECT;
      redirect_pc <= branch_target;
      if (flush_count != CNT_MAX) flush_count <= flush_count + CNT_ONE;
      if (branch_target[1:0] != 2'b00) misalign_err <= 1'b1;
    end else if (lu) begin
      if (stall_count != CNT_MAX) stall_count <= stall_count + CNT_ONE;
    end
  end

endmodule
